// File: rtl/bram_sdp.sv
// bram_sdp: simple-dual-port BRAM with byte enables, registered read and a clear sweep.
// Define BRAM_OUT_REG_EN to add a second output register stage (read latency 2).
module bram_sdp #(
  parameter int ADDRSIZE = 13,
  parameter int WORDSIZE = 16,
  parameter int BYTESIZE = 8,
  parameter logic [WORDSIZE-1:0] CLEAR_VALUE = '0,
  parameter int RDW_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  output logic                         busy,
  input  logic                         wr_en,
  input  logic [ADDRSIZE-1:0]          wr_addr,
  input  logic [WORDSIZE/BYTESIZE-1:0] wr_be,
  input  logic [WORDSIZE-1:0]          wr_data,
  input  logic                         rd_en,
  input  logic [ADDRSIZE-1:0]          rd_addr,
  output logic [WORDSIZE-1:0]          rd_data,
  output logic                         rd_valid
);
  localparam int LANES = WORDSIZE / BYTESIZE;
  localparam int DEPTH = 1 << ADDRSIZE;
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, nstate;
  logic [ADDRSIZE-1:0] cnt;
  logic [WORDSIZE-1:0] mem [DEPTH];
  logic [WORDSIZE-1:0] old, merged, d1;
  logic v1, rd_go, wr_go;
  assign busy = state == CLEAR;
  assign rd_go = rd_en & ~busy;
  assign wr_go = wr_en & ~busy;
  always_comb nstate = busy ? (&cnt ? IDLE : CLEAR) : (clear ? CLEAR : IDLE);
  always_comb begin
    old = mem[rd_addr];
    merged = old;
    for (int i = 0; i < LANES; i++)
      if (wr_be[i]) merged[i*BYTESIZE +: BYTESIZE] = wr_data[i*BYTESIZE +: BYTESIZE];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
    end else begin
      state <= nstate;
      cnt <= busy ? cnt + 1'b1 : '0;
    end
  // reset only holds the sweep at address 0; it never writes the array itself
  always_ff @(posedge clk)
    if (!rst) begin
      if (busy) mem[cnt] <= CLEAR_VALUE;
      else if (wr_en)
        for (int i = 0; i < LANES; i++)
          if (wr_be[i]) mem[wr_addr][i*BYTESIZE +: BYTESIZE] <= wr_data[i*BYTESIZE +: BYTESIZE];
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_go;
      if (rd_go) d1 <= (RDW_MODE == 1 && wr_go && wr_addr == rd_addr) ? merged : old;
    end
`ifdef BRAM_OUT_REG_EN
  logic [WORDSIZE-1:0] d2;
  logic v2;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d2 <= '0;
      v2 <= 1'b0;
    end else begin
      d2 <= d1;
      v2 <= v1;
    end
  assign rd_data = d2;
  assign rd_valid = v2;
`else
  assign rd_data = d1;
  assign rd_valid = v1;
`endif
endmodule

// File: tb/tb_bram_sdp.sv
// tb_bram_sdp: directed + random checks of bram_sdp (both RDW modes) against an array/queue model.
module tb_bram_sdp;
  localparam int AW = 4, N = 16;
  localparam logic [15:0] CV = 16'hA5A5;
`ifdef BRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 0, rst = 1, clear = 0, wr_en = 0, rd_en = 0;
  logic [AW-1:0] wr_addr = 0, rd_addr = 0;
  logic [1:0] wr_be = 0;
  logic [15:0] wr_data = 0;
  logic busy0, busy1, v0, v1;
  logic [15:0] d0, d1;
  always #5 clk = ~clk;
  bram_sdp #(.ADDRSIZE(AW), .WORDSIZE(16), .BYTESIZE(8), .CLEAR_VALUE(CV), .RDW_MODE(0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy0), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0));
  bram_sdp #(.ADDRSIZE(AW), .WORDSIZE(16), .BYTESIZE(8), .CLEAR_VALUE(CV), .RDW_MODE(1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .busy(busy1), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_be(wr_be), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1));
  logic [15:0] mm [N];
  int rem = N;
  logic [15:0] h0, h1;
  logic [16:0] q0 [$], q1 [$];
  logic [16:0] e0, e1;
  int checks = 0, fails = 0, vcnt = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic mreset();
    rem = N;
    h0 = 0;
    h1 = 0;
    q0 = {};
    q1 = {};
    for (int i = 0; i < LAT - 1; i++) begin
      q0.push_back('0);
      q1.push_back('0);
    end
  endtask
  task automatic cyc();
    logic [15:0] old, mg;
    logic rv;
    @(posedge clk);
    if (rst) begin
      mreset();
      e0 = '0;
      e1 = '0;
    end else begin
      rv = rem == 0 && rd_en;
      if (rv) begin
        old = mm[rd_addr];
        mg = old;
        if (wr_be[0]) mg[7:0] = wr_data[7:0];
        if (wr_be[1]) mg[15:8] = wr_data[15:8];
        h0 = old;
        h1 = (wr_en && wr_addr == rd_addr) ? mg : old;
      end
      if (rem == 0 && wr_en) begin
        if (wr_be[0]) mm[wr_addr][7:0] = wr_data[7:0];
        if (wr_be[1]) mm[wr_addr][15:8] = wr_data[15:8];
      end
      if (rem > 0) begin
        mm[N-rem] = CV;
        rem--;
      end else if (clear) rem = N;
      q0.push_back({rv, h0});
      q1.push_back({rv, h1});
      e0 = q0.pop_front();
      e1 = q1.pop_front();
    end
    #1;
    chk("busy0", busy0, rem > 0);
    chk("busy1", busy1, rem > 0);
    chk("valid0", v0, e0[16]);
    chk("data0", d0, e0[15:0]);
    chk("valid1", v1, e1[16]);
    chk("data1", d1, e1[15:0]);
    if (v0) vcnt++;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
    wr_be = be;
    cyc();
    wr_en = 0;
  endtask
  task automatic rd(input logic [AW-1:0] a);
    rd_en = 1;
    rd_addr = a;
    cyc();
    rd_en = 0;
    repeat (LAT - 1) cyc();
  endtask
  initial begin
    int n;
    mreset();
    repeat (2) cyc();
    rst = 0;
    n = 0;
    while (busy0 && n < 40) begin cyc(); n++; end
    chk("sweep_len", n, 16);
    vcnt = 0;
    rd_en = 1;
    for (int a = 0; a < N; a++) begin rd_addr = AW'(a); cyc(); end
    rd_en = 0;
    repeat (LAT) cyc();
    chk("t1_pulses", vcnt, 16);
    chk("t1_last", d0, CV);
    wr(3, 16'h1234, 2'b11);
    rd(3);
    chk("t2_valid", v0, 1);
    chk("t2_data", d0, 16'h1234);
    wr(5, 16'hFFFF, 2'b11);
    wr(5, 16'h0000, 2'b01);
    wr(5, 16'hBEEF, 2'b00);
    rd(5);
    chk("t3_data", d0, 16'hFF00);
    wr(7, 16'h1111, 2'b11);
    wr_en = 1; wr_addr = 7; wr_data = 16'h2222; wr_be = 2'b10;
    rd_en = 1; rd_addr = 7;
    cyc();
    wr_en = 0; rd_en = 0;
    repeat (LAT - 1) cyc();
    chk("t4_old", d0, 16'h1111);
    chk("t4_new", d1, 16'h2211);
    rd(7);
    chk("t4_after0", d0, 16'h2211);
    chk("t4_after1", d1, 16'h2211);
    rd(3);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t6_valid", v0, 0);
      chk("t6_hold", d0, 16'h1234);
    end
    clear = 1;
    cyc();
    clear = 0;
    vcnt = 0;
    wr_en = 1; wr_addr = 2; wr_data = 16'h5555; wr_be = 2'b11;
    rd_en = 1; rd_addr = 2;
    n = 0;
    while (busy0 && n < 40) begin cyc(); n++; end
    chk("t5_sweep_len", n, 16);
    wr_en = 0; rd_en = 0;
    repeat (LAT) cyc();
    chk("t5_no_valid", vcnt, 0);
    rd(2);
    chk("t5_cleared", d0, CV);
    clear = 1;
    cyc();
    clear = 0;
    repeat (9) cyc();
    rst = 1;
    #1;
    chk("async_busy", busy0, 1);
    chk("async_data", d0, 0);
    chk("async_valid", v0, 0);
    cyc();
    rst = 0;
    n = 0;
    while (busy0 && n < 40) begin cyc(); n++; end
    chk("rst_sweep_len", n, 16);
    repeat (400) begin
      wr_en = 1'($urandom);
      rd_en = 1'($urandom);
      wr_addr = AW'($urandom_range(0, 3));
      rd_addr = AW'($urandom_range(0, 3));
      wr_be = 2'($urandom);
      wr_data = 16'($urandom);
      clear = ($urandom % 64) == 0;
      cyc();
    end
    clear = 0; wr_en = 0; rd_en = 0;
    repeat (LAT + 1) cyc();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/bram_sdp.md
Name: bram_sdp

Overview:
Parametrised simple-dual-port block RAM and the successor of the single-port 8K x 16 BRAM.
- Independent write port with byte enables and a registered read port with a valid strobe.
- Configurable read-during-write behaviour.
- Built-in clear sweep fills every word with a constant after reset or on request.
- Used as a sample/packet buffer between DSP and host-interface logic.

Parameters:
ADDRSIZE, 13, address width; DEPTH = 2^ADDRSIZE words
WORDSIZE, 16, data word width; must be an integer multiple of BYTESIZE
BYTESIZE, 8, bits per byte-enable lane
CLEAR_VALUE, 0, word value written to every address by the clear sweep
RDW_MODE, 0, same-address read/write collision: 0 = return old data, 1 = return merged new data

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
clear  in  1  single-cycle request to start a clear sweep
busy  out  1  high while a clear sweep is running; ports ignored
wr_en  in  1  write strobe
wr_addr  in  ADDRSIZE  write address
wr_be  in  WORDSIZE/BYTESIZE  per-lane write enable; lane i covers bits [i*BYTESIZE +: BYTESIZE]
wr_data  in  WORDSIZE  write data
rd_en  in  1  read strobe
rd_addr  in  ADDRSIZE  read address
rd_data  out  WORDSIZE  read data
rd_valid  out  1  one-cycle pulse marking rd_data as valid for the matching rd_en

Behaviour:
- Reset (async assert): rd_data=0, rd_valid=0, busy=1, FSM=CLEAR, sweep counter=0. Memory contents are not touched by reset itself.
- FSM states: CLEAR and IDLE.
- CLEAR: each cycle write CLEAR_VALUE to mem[counter] and increment counter.
  - When counter = DEPTH-1 is written: next state IDLE, busy=0.
  - Sweep takes exactly DEPTH cycles after rst deasserts.
- IDLE:
  - clear=1 -> CLEAR on the next edge, counter=0, busy=1 from that edge.
  - clear while already in CLEAR is ignored; the sweep is not restarted.
- While busy=1:
  - wr_en and rd_en are ignored: no user write, rd_valid stays 0.
  - rd_data holds its last value.
- Reset asserted mid-sweep: sweep restarts from address 0 after release; a full DEPTH cycles of busy follow.
- Write (IDLE, wr_en=1): on the edge, only lanes with wr_be[i]=1 are updated. wr_be=0 is a no-op.
- Read (IDLE, rd_en=1 at edge N): rd_data updated and rd_valid=1 at edge N+1 (latency 1).
  - rd_en=0: rd_valid=0 next cycle, rd_data holds.
  - Back-to-back reads sustain one word per cycle.
- Collision (wr_en & rd_en & wr_addr==rd_addr in same cycle):
  - RDW_MODE=0: rd_data = pre-write word.
  - RDW_MODE=1: rd_data = wr_data in enabled lanes, old word in the other lanes.
  - The memory update is identical in both modes.
- Addresses wrap naturally at ADDRSIZE bits; there is no out-of-range case.
- A clear request and a user write on the same IDLE cycle: the user write takes effect, then the sweep overwrites it.

Optional Feature:
BRAM_OUT_REG_EN
- Defined: one extra output register stage; read latency 2 (rd_en at edge N -> rd_data/rd_valid at edge N+2). rd_valid is pipelined alongside rd_data. Both stages reset to 0. Collision semantics apply to the first stage unchanged. Full throughput is kept.
- Undefined: latency 1 as above.

Test Plan:
1. ADDRSIZE=4, CLEAR_VALUE=16'hA5A5, release rst -> busy high for exactly 16 cycles, then 0. Read addr 0..15 back-to-back -> 16 rd_valid pulses, all 16'hA5A5.
2. Write 16'h1234 be=2'b11 at addr 3, then rd_en addr 3 -> rd_data=16'h1234 with rd_valid one cycle later (two with BRAM_OUT_REG_EN).
3. Write 16'hFFFF be=11 at addr 5, then 16'h0000 be=01 at addr 5, then write 16'hBEEF be=00 at addr 5 -> read addr 5 returns 16'hFF00.
4. addr 7 holds 16'h1111; same cycle write 16'h2222 be=10 + read addr 7 -> RDW_MODE=0 returns 16'h1111, RDW_MODE=1 returns 16'h2211. A later read returns 16'h2211 in both modes.
5. Pulse clear in IDLE, drive wr_en addr 2 data 16'h5555 and rd_en while busy -> no rd_valid pulses, addr 2 reads CLEAR_VALUE afterwards. Assert rst at sweep count 9 -> busy stays high for 16 full cycles after release.
6. After a read of 16'h1234, hold rd_en=0 for 5 cycles -> rd_valid=0, rd_data stays 16'h1234.
